// File: rtl/ttc_apb_access_lite13.sv
//------------------------------------------------------------------------------
// ttc_apb_access_lite13
//
// APB3 slave front end for one triple-timer-counter-lite timer. It turns APB
// transfers into one-cycle register-select strobes plus registered write data
// for ttc_timer_counter_lite13. It also multiplexes the timer's register values
// back onto prdata13, and it pulses clear_interrupt13 after the interrupt
// register has been read.
//
// Ports
//   pclk13, n_p_reset13        clock, asynchronous active-low reset
//   psel13, penable13,
//   pwrite13, paddr13,
//   pwdata13                   APB3 request (only pwdata13[15:0] is used)
//   prdata13, pready13,
//   pslverr13                  APB3 response
//   pwdata_out13               write data held for the timer
//   *_reg_sel13                one-cycle write strobes, one per RW register
//   clear_interrupt13          one-cycle clear pulse after a read of 0x54
//   *_reg13 (inputs)           readback values from the timer
//
// Transfer timing
//   write : setup, access (pready13 high)         -> strobe in the next cycle
//   read  : setup, access/wait, access/done (pready13 high)
//           The readback is sampled in the first access cycle.
//------------------------------------------------------------------------------
module ttc_apb_access_lite13 #(
    parameter int PADDR_W = 8
) (
    input  logic               pclk13,
    input  logic               n_p_reset13,
    input  logic               psel13,
    input  logic               penable13,
    input  logic               pwrite13,
    input  logic [PADDR_W-1:0] paddr13,
    input  logic [31:0]        pwdata13,
    output logic [31:0]        prdata13,
    output logic               pready13,
    output logic               pslverr13,
    output logic [15:0]        pwdata_out13,
    output logic               clk_ctrl_reg_sel13,
    output logic               cntr_ctrl_reg_sel13,
    output logic               interval_reg_sel13,
    output logic               match_1_reg_sel13,
    output logic               match_2_reg_sel13,
    output logic               match_3_reg_sel13,
    output logic               intr_en_reg_sel13,
    output logic               clear_interrupt13,
    input  logic [6:0]         clk_ctrl_reg13,
    input  logic [6:0]         cntr_ctrl_reg13,
    input  logic [15:0]        counter_val_reg13,
    input  logic [15:0]        interval_reg13,
    input  logic [15:0]        match_1_reg13,
    input  logic [15:0]        match_2_reg13,
    input  logic [15:0]        match_3_reg13,
    input  logic [5:0]         interrupt_reg13,
    input  logic [5:0]         interrupt_en_reg13
);

    //--------------------------------------------------------------------------
    // FSM encoding and address map
    //--------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_DONE = 2'd2;

    localparam logic [7:0] ADDR_CLK_CTRL  = 8'h00;
    localparam logic [7:0] ADDR_CNTR_CTRL = 8'h0C;
    localparam logic [7:0] ADDR_COUNTER   = 8'h18;
    localparam logic [7:0] ADDR_INTERVAL  = 8'h24;
    localparam logic [7:0] ADDR_MATCH_1   = 8'h30;
    localparam logic [7:0] ADDR_MATCH_2   = 8'h3C;
    localparam logic [7:0] ADDR_MATCH_3   = 8'h48;
    localparam logic [7:0] ADDR_INTR      = 8'h54;
    localparam logic [7:0] ADDR_INTR_EN   = 8'h60;

    // Bit positions in the one-hot write-select vector
    localparam int SEL_CLK_CTRL  = 0;
    localparam int SEL_CNTR_CTRL = 1;
    localparam int SEL_INTERVAL  = 2;
    localparam int SEL_MATCH_1   = 3;
    localparam int SEL_MATCH_2   = 4;
    localparam int SEL_MATCH_3   = 5;
    localparam int SEL_INTR_EN   = 6;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_rdata_q;      // readback captured in the first access cycle
    logic        r_rd_err;       // captured read targeted an unmapped address
    logic        r_rd_is_intr;   // captured read targeted the interrupt register
    logic [6:0]  r_sel;          // one-hot write strobes
    logic [15:0] r_pwdata_out;
    logic        r_clear;

    //--------------------------------------------------------------------------
    // Wires
    //--------------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic        w_upper_ok;
    logic        w_mapped;
    logic        w_read_only;
    logic        w_is_intr;
    logic [6:0]  w_wr_sel;
    logic [31:0] w_rd_mux;
    logic        w_wr_access;
    logic        w_wr_err;
    logic        w_wr_commit;
    logic        w_rd_setup;
    logic        w_unused_pwdata_hi;

    // Address bits above [7:0] must be zero for any register to match.
    generate
        if (PADDR_W > 8) begin : g_upper
            assign w_upper_ok = ~|paddr13[PADDR_W-1:8];
        end else begin : g_no_upper
            assign w_upper_ok = 1'b1;
        end
    endgenerate

    // The timer registers are at most 16 bits wide.
    assign w_unused_pwdata_hi = ^pwdata13[31:16];

    //--------------------------------------------------------------------------
    // Address decode and readback mux
    //--------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path through the case statement can leave it unassigned and infer
    // a latch.
    always_comb begin
        w_mapped    = 1'b0;
        w_read_only = 1'b0;
        w_is_intr   = 1'b0;
        w_wr_sel    = '0;
        w_rd_mux    = '0;
        if (w_upper_ok) begin
            case (paddr13[7:0])
                ADDR_CLK_CTRL: begin
                    w_mapped                = 1'b1;
                    w_wr_sel[SEL_CLK_CTRL]  = 1'b1;
                    w_rd_mux                = {25'd0, clk_ctrl_reg13};
                end
                ADDR_CNTR_CTRL: begin
                    w_mapped                = 1'b1;
                    w_wr_sel[SEL_CNTR_CTRL] = 1'b1;
                    w_rd_mux                = {25'd0, cntr_ctrl_reg13};
                end
                ADDR_COUNTER: begin
                    w_mapped                = 1'b1;
                    w_read_only             = 1'b1;
                    w_rd_mux                = {16'd0, counter_val_reg13};
                end
                ADDR_INTERVAL: begin
                    w_mapped                = 1'b1;
                    w_wr_sel[SEL_INTERVAL]  = 1'b1;
                    w_rd_mux                = {16'd0, interval_reg13};
                end
                ADDR_MATCH_1: begin
                    w_mapped                = 1'b1;
                    w_wr_sel[SEL_MATCH_1]   = 1'b1;
                    w_rd_mux                = {16'd0, match_1_reg13};
                end
                ADDR_MATCH_2: begin
                    w_mapped                = 1'b1;
                    w_wr_sel[SEL_MATCH_2]   = 1'b1;
                    w_rd_mux                = {16'd0, match_2_reg13};
                end
                ADDR_MATCH_3: begin
                    w_mapped                = 1'b1;
                    w_wr_sel[SEL_MATCH_3]   = 1'b1;
                    w_rd_mux                = {16'd0, match_3_reg13};
                end
                ADDR_INTR: begin
                    w_mapped                = 1'b1;
                    w_read_only             = 1'b1;
                    w_is_intr               = 1'b1;
                    w_rd_mux                = {26'd0, interrupt_reg13};
                end
                ADDR_INTR_EN: begin
                    w_mapped                = 1'b1;
                    w_wr_sel[SEL_INTR_EN]   = 1'b1;
                    w_rd_mux                = {26'd0, interrupt_en_reg13};
                end
                default: begin
                    w_mapped                = 1'b0;
                end
            endcase
        end
    end

    // A write completes in its first access cycle (zero wait states).
    assign w_wr_access = (r_state == ST_IDLE) & psel13 & penable13 & pwrite13;
    assign w_wr_err    = ~w_mapped | w_read_only;
    assign w_wr_commit = w_wr_access & ~w_wr_err;

    // A read is recognised in its setup cycle. The first access cycle is then
    // RD_WAIT, where the readback is sampled, and the second is RD_DONE. An
    // access-phase read seen in IDLE has no setup that this block observed
    // (for example, a transfer cut off by reset), so it is ignored.
    assign w_rd_setup = (r_state == ST_IDLE) & psel13 & ~penable13 & ~pwrite13;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:    w_state_nxt = w_rd_setup ? ST_RD_WAIT : ST_IDLE;
            // If psel13 drops while waiting, the master has abandoned the
            // transfer. Return to IDLE without a response or a clear.
            ST_RD_WAIT: w_state_nxt = psel13 ? ST_RD_DONE : ST_IDLE;
            ST_RD_DONE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Sequential state
    //--------------------------------------------------------------------------
    // NOTE: state is updated only with non-blocking assignments. Every
    // always_ff block then reads the pre-edge values, so the outcome does not
    // depend on the order in which the simulator runs the blocks.
    always_ff @(posedge pclk13 or negedge n_p_reset13) begin
        if (!n_p_reset13) begin
            r_state      <= ST_IDLE;
            r_rdata_q    <= '0;
            r_rd_err     <= 1'b0;
            r_rd_is_intr <= 1'b0;
            r_sel        <= '0;
            r_pwdata_out <= '0;
            r_clear      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_RD_WAIT) begin
                r_rdata_q    <= w_rd_mux;
                r_rd_err     <= ~w_mapped;
                r_rd_is_intr <= w_is_intr;
            end

            // Strobes are high only in the cycle after the write completes.
            r_sel <= w_wr_commit ? w_wr_sel : 7'd0;
            if (w_wr_commit) begin
                r_pwdata_out <= pwdata13[15:0];
            end

            r_clear <= (r_state == ST_RD_DONE) & r_rd_is_intr;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    // pready13 and pslverr13 depend directly on the APB inputs, so they are
    // also gated by reset. This holds them low during reset even when a master
    // is still driving an access phase.
    assign pready13  = n_p_reset13 & (w_wr_access | (r_state == ST_RD_DONE));
    assign pslverr13 = n_p_reset13 & ((w_wr_access & w_wr_err) |
                                      ((r_state == ST_RD_DONE) & r_rd_err));

    // Read data is driven only while a read completes. It is zero for a
    // completing write, for an idle bus and for an unmapped read. An unmapped
    // address already muxes to zero.
    assign prdata13 = (r_state == ST_RD_DONE) ? r_rdata_q : 32'd0;

    assign pwdata_out13        = r_pwdata_out;
    assign clk_ctrl_reg_sel13  = r_sel[SEL_CLK_CTRL];
    assign cntr_ctrl_reg_sel13 = r_sel[SEL_CNTR_CTRL];
    assign interval_reg_sel13  = r_sel[SEL_INTERVAL];
    assign match_1_reg_sel13   = r_sel[SEL_MATCH_1];
    assign match_2_reg_sel13   = r_sel[SEL_MATCH_2];
    assign match_3_reg_sel13   = r_sel[SEL_MATCH_3];
    assign intr_en_reg_sel13   = r_sel[SEL_INTR_EN];
    assign clear_interrupt13   = r_clear;

endmodule

// File: tb/tb_ttc_apb_access_lite13.sv
//------------------------------------------------------------------------------
// tb_ttc_apb_access_lite13
//
// Table-driven bench for ttc_apb_access_lite13, plus hand-written sequences for
// reset, back-to-back transfers and read abort. A small timer model loads its
// RW registers from the write strobes, so writes can be read back.
//------------------------------------------------------------------------------
module tb_ttc_apb_access_lite13;

    logic        pclk13 = 1'b0;
    logic        n_p_reset13;
    logic        psel13, penable13, pwrite13;
    logic [7:0]  paddr13;
    logic [31:0] pwdata13;
    logic [31:0] prdata13;
    logic        pready13, pslverr13;
    logic [15:0] pwdata_out13;
    logic        clk_ctrl_reg_sel13, cntr_ctrl_reg_sel13, interval_reg_sel13;
    logic        match_1_reg_sel13, match_2_reg_sel13, match_3_reg_sel13;
    logic        intr_en_reg_sel13, clear_interrupt13;

    // Timer model registers
    logic [6:0]  clk_ctrl_reg13     = '0;
    logic [6:0]  cntr_ctrl_reg13    = '0;
    logic [15:0] interval_reg13     = '0;
    logic [15:0] match_1_reg13      = '0;
    logic [15:0] match_2_reg13      = '0;
    logic [15:0] match_3_reg13      = '0;
    logic [5:0]  interrupt_en_reg13 = '0;
    logic [15:0] counter_val_reg13;
    logic [5:0]  interrupt_reg13;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_pwdata = '0;

    wire [6:0] w_sel = {intr_en_reg_sel13, match_3_reg_sel13, match_2_reg_sel13,
                        match_1_reg_sel13, interval_reg_sel13, cntr_ctrl_reg_sel13,
                        clk_ctrl_reg_sel13};

    always #5 pclk13 = ~pclk13;

    ttc_apb_access_lite13 #(.PADDR_W(8)) u_dut (
        .pclk13              (pclk13),
        .n_p_reset13         (n_p_reset13),
        .psel13              (psel13),
        .penable13           (penable13),
        .pwrite13            (pwrite13),
        .paddr13             (paddr13),
        .pwdata13            (pwdata13),
        .prdata13            (prdata13),
        .pready13            (pready13),
        .pslverr13           (pslverr13),
        .pwdata_out13        (pwdata_out13),
        .clk_ctrl_reg_sel13  (clk_ctrl_reg_sel13),
        .cntr_ctrl_reg_sel13 (cntr_ctrl_reg_sel13),
        .interval_reg_sel13  (interval_reg_sel13),
        .match_1_reg_sel13   (match_1_reg_sel13),
        .match_2_reg_sel13   (match_2_reg_sel13),
        .match_3_reg_sel13   (match_3_reg_sel13),
        .intr_en_reg_sel13   (intr_en_reg_sel13),
        .clear_interrupt13   (clear_interrupt13),
        .clk_ctrl_reg13      (clk_ctrl_reg13),
        .cntr_ctrl_reg13     (cntr_ctrl_reg13),
        .counter_val_reg13   (counter_val_reg13),
        .interval_reg13      (interval_reg13),
        .match_1_reg13       (match_1_reg13),
        .match_2_reg13       (match_2_reg13),
        .match_3_reg13       (match_3_reg13),
        .interrupt_reg13     (interrupt_reg13),
        .interrupt_en_reg13  (interrupt_en_reg13)
    );

    // Timer model: each RW register loads the low bits of pwdata_out13 on its
    // strobe.
    always @(posedge pclk13) begin
        if (clk_ctrl_reg_sel13)  clk_ctrl_reg13     <= pwdata_out13[6:0];
        if (cntr_ctrl_reg_sel13) cntr_ctrl_reg13    <= pwdata_out13[6:0];
        if (interval_reg_sel13)  interval_reg13     <= pwdata_out13;
        if (match_1_reg_sel13)   match_1_reg13      <= pwdata_out13;
        if (match_2_reg_sel13)   match_2_reg13      <= pwdata_out13;
        if (match_3_reg_sel13)   match_3_reg13      <= pwdata_out13;
        if (intr_en_reg_sel13)   interrupt_en_reg13 <= pwdata_out13[5:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        psel13 = 1'b0; penable13 = 1'b0; pwrite13 = 1'b0;
    endtask

    // Complete write: setup, access. The strobe cycle follows.
    task automatic apb_write(input string tag, input logic [7:0] addr,
                             input logic [15:0] data, input logic exp_err,
                             input logic [6:0] exp_sel);
        @(posedge pclk13); #1;
        psel13 = 1'b1; penable13 = 1'b0; pwrite13 = 1'b1;
        paddr13 = addr; pwdata13 = {16'hDEAD, data};
        @(negedge pclk13);
        check({tag, " setup pready"}, 32'(pready13), 32'd0);
        @(posedge pclk13); #1;
        penable13 = 1'b1;
        @(negedge pclk13);
        check({tag, " access pready"}, 32'(pready13), 32'd1);
        check({tag, " pslverr"}, 32'(pslverr13), 32'(exp_err));
        check({tag, " prdata on write"}, prdata13, 32'd0);
        if (!exp_err) exp_pwdata = data;
        @(posedge pclk13); #1;
        bus_idle();
        @(negedge pclk13);
        check({tag, " strobes"}, 32'(w_sel), 32'(exp_sel));
        check({tag, " pwdata_out"}, 32'(pwdata_out13), 32'(exp_pwdata));
        check({tag, " no clear"}, 32'(clear_interrupt13), 32'd0);
        @(negedge pclk13);
        check({tag, " strobe one cycle"}, 32'(w_sel), 32'd0);
    endtask

    // Complete read: setup, wait, done. The clear cycle follows.
    task automatic apb_read(input string tag, input logic [7:0] addr,
                            input logic exp_err, input logic [31:0] exp_rdata,
                            input logic exp_clr);
        @(posedge pclk13); #1;
        psel13 = 1'b1; penable13 = 1'b0; pwrite13 = 1'b0; paddr13 = addr;
        @(negedge pclk13);
        check({tag, " setup pready"}, 32'(pready13), 32'd0);
        @(posedge pclk13); #1;
        penable13 = 1'b1;
        @(negedge pclk13);
        check({tag, " wait pready"}, 32'(pready13), 32'd0);
        check({tag, " wait prdata"}, prdata13, 32'd0);
        @(negedge pclk13);
        check({tag, " done pready"}, 32'(pready13), 32'd1);
        check({tag, " pslverr"}, 32'(pslverr13), 32'(exp_err));
        check({tag, " prdata"}, prdata13, exp_rdata);
        @(posedge pclk13); #1;
        bus_idle();
        @(negedge pclk13);
        check({tag, " clear"}, 32'(clear_interrupt13), 32'(exp_clr));
        check({tag, " no strobe"}, 32'(w_sel), 32'd0);
        check({tag, " prdata after"}, prdata13, 32'd0);
        @(negedge pclk13);
        check({tag, " clear one cycle"}, 32'(clear_interrupt13), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [6:0]  sel;
        logic        clr;
    } vec_t;

    localparam int N_VEC = 20;
    vec_t vecs[N_VEC];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    addr   wdata     err   rdata         sel         clr
        vecs[0]  = '{1'b1, 8'h24, 16'h1234, 1'b0, 32'h0,        7'b0000100, 1'b0};
        vecs[1]  = '{1'b0, 8'h24, 16'h0,    1'b0, 32'h00001234, 7'b0,       1'b0};
        vecs[2]  = '{1'b1, 8'h00, 16'hFFFF, 1'b0, 32'h0,        7'b0000001, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 16'h0,    1'b0, 32'h0000007F, 7'b0,       1'b0};
        vecs[4]  = '{1'b1, 8'h30, 16'hA5A5, 1'b0, 32'h0,        7'b0001000, 1'b0};
        vecs[5]  = '{1'b0, 8'h30, 16'h0,    1'b0, 32'h0000A5A5, 7'b0,       1'b0};
        vecs[6]  = '{1'b1, 8'h3C, 16'h0001, 1'b0, 32'h0,        7'b0010000, 1'b0};
        vecs[7]  = '{1'b1, 8'h48, 16'h8000, 1'b0, 32'h0,        7'b0100000, 1'b0};
        vecs[8]  = '{1'b0, 8'h48, 16'h0,    1'b0, 32'h00008000, 7'b0,       1'b0};
        vecs[9]  = '{1'b1, 8'h60, 16'h00FF, 1'b0, 32'h0,        7'b1000000, 1'b0};
        vecs[10] = '{1'b0, 8'h60, 16'h0,    1'b0, 32'h0000003F, 7'b0,       1'b0};
        vecs[11] = '{1'b0, 8'h18, 16'h0,    1'b0, 32'h0000BEEF, 7'b0,       1'b0};
        vecs[12] = '{1'b0, 8'h54, 16'h0,    1'b0, 32'h00000015, 7'b0,       1'b1};
        vecs[13] = '{1'b1, 8'h18, 16'hABCD, 1'b1, 32'h0,        7'b0,       1'b0};
        vecs[14] = '{1'b1, 8'h54, 16'h0000, 1'b1, 32'h0,        7'b0,       1'b0};
        vecs[15] = '{1'b0, 8'h04, 16'h0,    1'b1, 32'h0,        7'b0,       1'b0};
        vecs[16] = '{1'b1, 8'h04, 16'h5555, 1'b1, 32'h0,        7'b0,       1'b0};
        vecs[17] = '{1'b0, 8'hFF, 16'h0,    1'b1, 32'h0,        7'b0,       1'b0};
        vecs[18] = '{1'b0, 8'h3C, 16'h0,    1'b0, 32'h00000001, 7'b0,       1'b0};
        vecs[19] = '{1'b1, 8'h5C, 16'h7777, 1'b1, 32'h0,        7'b0,       1'b0};

        n_p_reset13 = 1'b0;
        bus_idle();
        paddr13 = '0; pwdata13 = '0;
        counter_val_reg13 = 16'hBEEF;
        interrupt_reg13   = 6'h15;

        // Reset state
        @(negedge pclk13); @(negedge pclk13);
        check("reset pready", 32'(pready13), 32'd0);
        check("reset pslverr", 32'(pslverr13), 32'd0);
        check("reset prdata", prdata13, 32'd0);
        check("reset pwdata_out", 32'(pwdata_out13), 32'd0);
        check("reset strobes", 32'(w_sel), 32'd0);
        check("reset clear", 32'(clear_interrupt13), 32'd0);
        @(posedge pclk13); #1;
        n_p_reset13 = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            if (vecs[i].wr)
                apb_write($sformatf("vec%0d wr", i), vecs[i].addr, vecs[i].wdata,
                          vecs[i].err, vecs[i].sel);
            else
                apb_read($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].err,
                         vecs[i].rdata, vecs[i].clr);
        end

        // Back-to-back: the write to 0x0C is followed directly by a read of 0x0C.
        @(posedge pclk13); #1;
        psel13 = 1'b1; penable13 = 1'b0; pwrite13 = 1'b1;
        paddr13 = 8'h0C; pwdata13 = 32'h0000_0055;
        @(posedge pclk13); #1;
        penable13 = 1'b1;
        @(negedge pclk13);
        check("b2b write pready", 32'(pready13), 32'd1);
        check("b2b write pslverr", 32'(pslverr13), 32'd0);
        @(posedge pclk13); #1;
        penable13 = 1'b0; pwrite13 = 1'b0;
        @(negedge pclk13);
        check("b2b strobe in read setup", 32'(w_sel), 32'b0000010);
        check("b2b pwdata_out", 32'(pwdata_out13), 32'h0055);
        exp_pwdata = 16'h0055;
        @(posedge pclk13); #1;
        penable13 = 1'b1;
        @(negedge pclk13);
        check("b2b read wait pready", 32'(pready13), 32'd0);
        check("b2b strobe gone", 32'(w_sel), 32'd0);
        @(negedge pclk13);
        check("b2b read done pready", 32'(pready13), 32'd1);
        check("b2b read prdata", prdata13, 32'h00000055);
        @(posedge pclk13); #1;
        bus_idle();
        @(negedge pclk13);
        check("b2b no clear", 32'(clear_interrupt13), 32'd0);

        // Read abort: psel13 drops in the first access cycle of a read of 0x54.
        @(posedge pclk13); #1;
        psel13 = 1'b1; penable13 = 1'b0; pwrite13 = 1'b0; paddr13 = 8'h54;
        @(posedge pclk13); #1;
        bus_idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk13);
            check($sformatf("abort pready c%0d", k), 32'(pready13), 32'd0);
            check($sformatf("abort clear c%0d", k), 32'(clear_interrupt13), 32'd0);
        end

        // Reset during RD_WAIT of a read of 0x54
        @(posedge pclk13); #1;
        psel13 = 1'b1; penable13 = 1'b0; pwrite13 = 1'b0; paddr13 = 8'h54;
        @(posedge pclk13); #1;
        penable13 = 1'b1;
        @(negedge pclk13);
        check("rst-mid wait pready", 32'(pready13), 32'd0);
        #1 n_p_reset13 = 1'b0;
        #1;
        check("rst-mid pready", 32'(pready13), 32'd0);
        check("rst-mid pslverr", 32'(pslverr13), 32'd0);
        check("rst-mid prdata", prdata13, 32'd0);
        check("rst-mid pwdata_out", 32'(pwdata_out13), 32'd0);
        check("rst-mid strobes", 32'(w_sel), 32'd0);
        check("rst-mid clear", 32'(clear_interrupt13), 32'd0);
        exp_pwdata = '0;
        @(posedge pclk13); #1;
        n_p_reset13 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk13);
            check($sformatf("post-rst pready c%0d", k), 32'(pready13), 32'd0);
            check($sformatf("post-rst clear c%0d", k), 32'(clear_interrupt13), 32'd0);
            check($sformatf("post-rst strobes c%0d", k), 32'(w_sel), 32'd0);
        end
        @(posedge pclk13); #1;
        bus_idle();
        @(negedge pclk13);
        check("post-rst idle clear", 32'(clear_interrupt13), 32'd0);

        apb_read("post-rst rd", 8'h24, 1'b0, 32'h00001234, 1'b0);
        check("post-rst pwdata_out held", 32'(pwdata_out13), 32'(exp_pwdata));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
